// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - 32x32 register file with two registered read ports and optional write bypass
module reg_bank #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int SP_RESET = 227,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam int NREGS  = 2 ** ADDR_W;
    localparam int SP_IDX = 29;

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic              wr_en;

    // r0 is never stored; its reset-zero flop is simply never written
    assign wr_en = reg_write && (write_reg != '0);

    always_comb begin
        val1 = regs[read_reg1];
        if ((BYPASS != 0) && reg_write && (write_reg == read_reg1)) begin
            val1 = write_data;
        end
        if (read_reg1 == '0) begin
            val1 = '0;
        end

        val2 = regs[read_reg2];
        if ((BYPASS != 0) && reg_write && (write_reg == read_reg2)) begin
            val2 = write_data;
        end
        if (read_reg2 == '0) begin
            val2 = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (i == SP_IDX) ? DATA_W'(SP_RESET) : '0;
            end
            read_data1 <= '0;
            read_data2 <= '0;
        end else begin
            if (wr_en) begin
                regs[write_reg] <= write_data;
            end
            read_data1 <= val1;
            read_data2 <= val2;
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// tb/tb_reg_bank.sv - self-checking bench for reg_bank, bypass and non-bypass builds side by side
module tb_reg_bank;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    logic [31:0] mdl [32];

    always #5 clk = ~clk;

    reg_bank #(.DATA_W(32), .ADDR_W(5), .SP_RESET(227), .BYPASS(1)) u_byp (
        .clk(clk), .reset_n(reset_n), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(rd1_b), .read_data2(rd2_b)
    );

    reg_bank #(.DATA_W(32), .ADDR_W(5), .SP_RESET(227), .BYPASS(0)) u_nob (
        .clk(clk), .reset_n(reset_n), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(rd1_n), .read_data2(rd2_n)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1b;
        logic [31:0] e2b;
        logic [31:0] e1n;
        logic [31:0] e2n;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = (i == 29) ? 32'd227 : 32'd0;
    endtask

    function automatic logic [31:0] model_val(input logic [4:0] n, input bit byp,
                                              input logic we, input logic [4:0] wa,
                                              input logic [31:0] wd);
        if (n == 0) return 32'd0;
        if (byp && we && wa == n) return wd;
        return mdl[n];
    endfunction

    // Called on a falling edge; returns on the next falling edge with outputs checked against the model.
    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2, input string tag);
        logic [31:0] e1b, e2b, e1n, e2n;
        reg_write  = we;
        write_reg  = wa;
        write_data = wd;
        read_reg1  = r1;
        read_reg2  = r2;
        e1b = model_val(r1, 1'b1, we, wa, wd);
        e2b = model_val(r2, 1'b1, we, wa, wd);
        e1n = model_val(r1, 1'b0, we, wa, wd);
        e2n = model_val(r2, 1'b0, we, wa, wd);
        if (we && wa != 0) mdl[wa] = wd;
        @(posedge clk);
        @(negedge clk);
        chk({tag, " byp rd1"}, rd1_b, e1b);
        chk({tag, " byp rd2"}, rd2_b, e2b);
        chk({tag, " nob rd1"}, rd1_n, e1n);
        chk({tag, " nob rd2"}, rd2_n, e2n);
    endtask

    vec_t tbl [8];

    initial begin
        tbl[0] = '{1'b0, 5'd29, 32'hFFFFFFFF, 5'd29, 5'd5,  32'd227, 32'd0, 32'd227, 32'd0};
        tbl[1] = '{1'b1, 5'd8,  32'hDEADBEEF, 5'd0,  5'd8,  32'd0, 32'hDEADBEEF, 32'd0, 32'd0};
        tbl[2] = '{1'b0, 5'd0,  32'h0,        5'd8,  5'd0,  32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 32'd0};
        tbl[3] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'd0, 32'd0, 32'd0, 32'd0};
        tbl[4] = '{1'b0, 5'd0,  32'h12345678, 5'd0,  5'd8,  32'd0, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF};
        tbl[5] = '{1'b1, 5'd31, 32'h00400008, 5'd31, 5'd31, 32'h00400008, 32'h00400008, 32'd0, 32'd0};
        tbl[6] = '{1'b0, 5'd31, 32'h0,        5'd31, 5'd31, 32'h00400008, 32'h00400008, 32'h00400008, 32'h00400008};
        tbl[7] = '{1'b0, 5'd29, 32'hFFFFFFFF, 5'd29, 5'd29, 32'd227, 32'd227, 32'd227, 32'd227};

        reset_n = 1'b0; reg_write = 1'b0; write_reg = '0; write_data = '0;
        read_reg1 = '0; read_reg2 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Put nonzero state in r5 and on the outputs, then reset mid-cycle during a write
        step(1'b1, 5'd5, 32'h00000055, 5'd5, 5'd29, "pre");
        step(1'b1, 5'd5, 32'h000000AA, 5'd5, 5'd5,  "pre2");
        @(posedge clk);
        #2;
        reg_write = 1'b1; write_reg = 5'd5; write_data = 32'hCAFEF00D;
        reset_n = 1'b0;
        #1;
        chk("reset rd1 byp", rd1_b, 32'd0);
        chk("reset rd2 byp", rd2_b, 32'd0);
        chk("reset rd1 nob", rd1_n, 32'd0);
        chk("reset rd2 nob", rd2_n, 32'd0);
        model_reset();
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("reset hold rd1", rd1_b, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].r1, tbl[i].r2, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d const byp rd1", i), rd1_b, tbl[i].e1b);
            chk($sformatf("tbl%0d const byp rd2", i), rd2_b, tbl[i].e2b);
            chk($sformatf("tbl%0d const nob rd1", i), rd1_n, tbl[i].e1n);
            chk($sformatf("tbl%0d const nob rd2", i), rd2_n, tbl[i].e2n);
        end

        for (int i = 1; i < 32; i++) begin
            step(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), $sformatf("fill%0d", i));
        end
        for (int n = 0; n < 32; n++) begin
            step(1'b0, 5'(n), 32'hFFFFFFFF, 5'(n), 5'(31 - n), $sformatf("pair%0d", n));
            chk($sformatf("pair%0d formula", n), rd1_b, (n == 0) ? 32'd0 : 32'(n) * 32'h01010101);
        end

        // Random traffic; reads are biased toward the write index to exercise bypass
        for (int k = 0; k < 400; k++) begin
            logic        we;
            logic [4:0]  wa, r1, r2;
            logic [31:0] wd;
            we = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            step(we, wa, wd, r1, r2, $sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- 32-entry x 32-bit general-purpose register file for the multicycle MIPS datapath.
- It is the consumer end of the write-register select path. Its write port takes the 5-bit destination index (rt, 29, 31 or rd) plus write data and a write enable from control.
- Two read ports supply the rs/rt operands. Read data is registered, so the bank also acts as the A/B operand latches for the next cycle.

Parameters:
- DATA_W, 32, width of each register and data port.
- ADDR_W, 5, register index width (2**ADDR_W entries).
- SP_RESET, 227, reset value of register 29 (stack pointer).
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read; 0 = the read returns the pre-write value.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- reg_write  input  1  write enable from the control unit.
- write_reg  input  ADDR_W  destination register index (output of the write-register select).
- write_data  input  DATA_W  value to store.
- read_reg1  input  ADDR_W  source index for port 1 (instruction [25..21]).
- read_reg2  input  ADDR_W  source index for port 2 (instruction [20..16]).
- read_data1  output  DATA_W  registered contents of read_reg1.
- read_data2  output  DATA_W  registered contents of read_reg2.

Behaviour:
- Reset:
  - On reset_n low, asynchronously and immediately: all registers = 0 except r29 = SP_RESET; read_data1 = read_data2 = 0.
  - Reset has priority over everything and may arrive mid-write; any write in flight is discarded.
  - After reset_n deasserts, the first rising edge performs normal operation.
- Write:
  - On the rising edge with reg_write = 1 and write_reg != 0: the register at write_reg takes write_data.
  - Writes to r0 are ignored; r0 always reads 0.
  - With reg_write = 0, no register changes, whatever write_reg and write_data hold.
- Read:
  - On every rising edge, read_data1 <= value(read_reg1) and read_data2 <= value(read_reg2).
  - Latency is 1 cycle from address to output. The outputs hold until the next edge.
  - The outputs are updated every cycle; there is no read enable.
- value(n):
  - 0 if n == 0.
  - Otherwise, if BYPASS = 1 and reg_write = 1 and write_reg == n, value is write_data.
  - Otherwise, value is the stored register contents before this edge.
- Simultaneous events:
  - Both ports may read the same index; both get the same value.
  - Both ports may match the write address; both get the bypassed value.
  - A write to r0 with a read of r0 returns 0, even with BYPASS = 1.
- Arithmetic: none. Data is stored and passed unmodified at full DATA_W width.
- Index range: indices are never out of range (2**ADDR_W entries are fully decoded).

Test Plan:
1. Assert reset_n = 0 mid-cycle with reg_write = 1. Required: read_data1 and read_data2 = 0 immediately. After release, read r29 and r5. Required: 227 and 0 one edge later.
2. Write r8 = 0xDEADBEEF, then on the next cycle set read_reg1 = 8, read_reg2 = 0. Required: after one edge, read_data1 = 0xDEADBEEF and read_data2 = 0.
3. Write r0 = 0x12345678, then read r0 on both ports. Required: 0 on both; no other register changes.
4. With BYPASS = 1: in the same cycle, write r31 = 0x00400008 and read r31 on both ports. Required: 0x00400008 on both outputs after that edge. Rerun with BYPASS = 0. Required: old r31 value (0) on that edge, 0x00400008 on the next.
5. With reg_write = 0, drive write_reg = 29 and write_data = 0xFFFFFFFF, then read r29. Required: 227 is unchanged.
6. Write each r1..r31 = index*0x01010101. Then read all pairs (n, 31-n). Required: every read matches the written value with 1-cycle latency; r0 reads 0.
